axis_fifo_scheduler: RTL and testbench

//  Round-robin scheduler that shares one downstream AXI4-Stream consumer between
//  NUM_PORTS requesters, typically the master sides of per-channel asynchronous FIFOs.

---
 rtl/axis_fifo_scheduler.sv | 158 +++++++++++++++
 tb/tb_axis_fifo_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_scheduler.sv
// axis_fifo_scheduler
//   Round-robin scheduler that shares one downstream AXI4-Stream consumer
//   between NUM_PORTS requesters. One port is granted at a time for a burst
//   of up to cfg_data beats (0 behaves as 1), then the grant rotates. The
//   output stage is a single register that sustains one beat per clock.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant; scan s_axis_tvalid from ptr for the next requester
//   GRANT | port sel owns the output; beats move while load_en allows
//
// Ports
//   aclk, aresetn    clock, asynchronous active-low reset
//   cfg_data         burst length in beats
//   sts_data         one-hot current grant, 0 when idle
//   s_axis_*         NUM_PORTS upstream streams, port i at [i*W +: W]
//   m_axis_*         registered downstream stream
module axis_fifo_scheduler #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int NUM_PORTS        = 4,
    parameter int CNTR_WIDTH       = 8
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [CNTR_WIDTH-1:0]                 cfg_data,
    output logic [NUM_PORTS-1:0]                  sts_data,
    input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                  s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW = PW + 1;
    localparam logic [SW-1:0] NP_W = SW'(NUM_PORTS);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               ptr_q, ptr_d;
    logic [PW-1:0]               sel_q, sel_d;
    logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;

    logic                  load_en;
    logic                  sel_valid;
    logic                  accept;
    logic                  last_beat;
    logic [CNTR_WIDTH-1:0] limit;
    logic [PW-1:0]         sel_next;
    logic                  found;
    logic [PW-1:0]         found_idx;

    assign load_en   = ~tvalid_q | m_axis_tready;
    assign sel_valid = s_axis_tvalid[sel_q];
    assign accept    = (state_q == ST_GRANT) & sel_valid & load_en;
    assign limit     = (cfg_data == '0) ? CNTR_WIDTH'(1) : cfg_data;
    assign last_beat = (cnt_q == limit - CNTR_WIDTH'(1));
    assign sel_next  = (sel_q == PW'(NUM_PORTS - 1)) ? '0 : sel_q + PW'(1);

    // Scan from the highest offset down so the last hit, i.e. the lowest
    // offset from ptr, wins without needing a loop break.
    always_comb begin
        logic [SW-1:0] idx_w;
        idx_w     = '0;
        found     = 1'b0;
        found_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx_w = {1'b0, ptr_q} + SW'(i);
            if (idx_w >= NP_W) idx_w = idx_w - NP_W;
            if (s_axis_tvalid[idx_w[PW-1:0]]) begin
                found     = 1'b1;
                found_idx = idx_w[PW-1:0];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // A dry port ends its burst early; a stalled but valid port keeps
    // everything frozen, including the beat counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d   = found_idx;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept && last_beat) begin
                    state_d = ST_IDLE;
                    ptr_d   = sel_next;
                end else if (!sel_valid) begin
                    state_d = ST_IDLE;
                    ptr_d   = sel_next;
                end else if (accept) begin
                    cnt_d = cnt_q + CNTR_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sts_data      = '0;
        s_axis_tready = '0;
        if (state_q == ST_GRANT) begin
            sts_data[sel_q]      = 1'b1;
            s_axis_tready[sel_q] = load_en;
        end
    end

    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        if (accept) begin
            tdata_d  = s_axis_tdata[sel_q*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
            tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_fifo_scheduler.sv
// tb_axis_fifo_scheduler
//   Directed bench for axis_fifo_scheduler with four ports. Each port is a
//   simple source presenting base+count while count < len; accepted output
//   beats are logged with the cycle they were consumed in.
module tb_axis_fifo_scheduler;

    localparam int W  = 32;
    localparam int NP = 4;
    localparam int CW = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [CW-1:0]     cfg_data;
    logic [NP-1:0]     sts_data;
    logic [NP*W-1:0]   s_tdata;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [W-1:0]      m_tdata;
    logic              m_tvalid;
    logic              m_tready;

    axis_fifo_scheduler #(
        .AXIS_TDATA_WIDTH(W),
        .NUM_PORTS(NP),
        .CNTR_WIDTH(CW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_data     (cfg_data),
        .sts_data     (sts_data),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready)
    );

    always #5 aclk = ~aclk;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    int          src_cnt [NP];
    int          src_len [NP];
    logic [W-1:0] src_base [NP];
    bit          src_en [NP];
    bit          src_clr;
    logic [W-1:0] outq [$];
    int          outcyc [$];

    always_comb begin
        s_tdata  = '0;
        s_tvalid = '0;
        for (int p = 0; p < NP; p++) begin
            s_tdata[p*W +: W] = src_base[p] + W'(src_cnt[p]);
            s_tvalid[p]       = src_en[p] && (src_cnt[p] < src_len[p]);
        end
    end

    always @(posedge aclk) begin
        for (int p = 0; p < NP; p++) begin
            if (src_clr) src_cnt[p] <= 0;
            else if (s_tvalid[p] && s_tready[p]) src_cnt[p] <= src_cnt[p] + 1;
        end
    end

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (aresetn && m_tvalid && m_tready) begin
            outq.push_back(m_tdata);
            outcyc.push_back(cyc);
        end
    end

    function automatic logic [W-1:0] beat(input int i);
        if (i < outq.size()) return outq[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int bcyc(input int i);
        if (i < outcyc.size()) return outcyc[i];
        return -1000;
    endfunction

    task automatic apply_reset();
        aresetn  = 1'b0;
        m_tready = 1'b1;
        cfg_data = '0;
        for (int p = 0; p < NP; p++) begin
            src_en[p]   = 1'b0;
            src_len[p]  = 0;
            src_base[p] = '0;
        end
        src_clr = 1'b1;
        repeat (2) @(negedge aclk);
        outq.delete();
        outcyc.delete();
        src_clr = 1'b0;
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn  = 1'b0;
        m_tready = 1'b1;
        cfg_data = 8'd4;
        src_clr  = 1'b1;
        for (int p = 0; p < NP; p++) begin
            src_en[p]   = 1'b1;
            src_len[p]  = 100;
            src_base[p] = W'(p * 16);
        end
        repeat (3) @(negedge aclk);
        chk_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid);
        else pass_cnt++;
        chk_cnt++;
        if (s_tready !== 4'b0000) $display("FAIL reset_s_tready: got %b expected 0000", s_tready);
        else pass_cnt++;
        chk_cnt++;
        if (sts_data !== 4'b0000) $display("FAIL reset_sts: got %b expected 0000", sts_data);
        else pass_cnt++;
        chk_cnt++;
        if (m_tdata !== 32'h0) $display("FAIL reset_m_tdata: got %h expected 0", m_tdata);
        else pass_cnt++;
        src_clr = 1'b0;
    endtask

    task automatic test_single_port();
        int sts_good, sts_bad;
        logic [W-1:0] exp;
        apply_reset();
        cfg_data    = 8'd4;
        src_base[2] = 32'h10;
        src_len[2]  = 8;
        src_en[2]   = 1'b1;
        sts_good = 0;
        sts_bad  = 0;
        for (int c = 0; c < 60 && outq.size() < 8; c++) begin
            @(negedge aclk);
            if (sts_data == 4'b0100) sts_good++;
            else if (sts_data != 4'b0000) sts_bad++;
        end
        chk_cnt++;
        if (outq.size() < 8) $display("FAIL single_timeout: got %0d beats expected 8", outq.size());
        else pass_cnt++;
        repeat (4) @(negedge aclk);
        for (int i = 0; i < 8; i++) begin
            exp = 32'h10 + W'(i);
            chk_cnt++;
            if (beat(i) !== exp) $display("FAIL single_data[%0d]: got %h expected %h", i, beat(i), exp);
            else pass_cnt++;
        end
        chk_cnt++;
        if (bcyc(3) - bcyc(0) != 3) $display("FAIL single_burst_span: got %0d expected 3", bcyc(3) - bcyc(0));
        else pass_cnt++;
        chk_cnt++;
        if (bcyc(4) - bcyc(3) != 2) $display("FAIL single_idle_gap: got %0d expected 2", bcyc(4) - bcyc(3));
        else pass_cnt++;
        chk_cnt++;
        if (sts_good != 8) $display("FAIL single_sts_cycles: got %0d expected 8", sts_good);
        else pass_cnt++;
        chk_cnt++;
        if (sts_bad != 0) $display("FAIL single_sts_other: got %0d expected 0", sts_bad);
        else pass_cnt++;
        chk_cnt++;
        if (outq.size() != 8) $display("FAIL single_no_extra: got %0d expected 8", outq.size());
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [W-1:0] exp;
        apply_reset();
        cfg_data = 8'd2;
        for (int p = 0; p < NP; p++) begin
            src_base[p] = W'(p * 16);
            src_len[p]  = 100;
            src_en[p]   = 1'b1;
        end
        for (int c = 0; c < 100 && outq.size() < 16; c++) @(negedge aclk);
        chk_cnt++;
        if (outq.size() < 16) $display("FAIL fair_timeout: got %0d beats expected 16", outq.size());
        else pass_cnt++;
        // beat j comes from port (j/2)%4, and is that port's beat (j/8)*2 + j%2
        for (int j = 0; j < 16; j++) begin
            exp = W'(((j / 2) % 4) * 16 + (j / 8) * 2 + (j % 2));
            chk_cnt++;
            if (beat(j) !== exp) $display("FAIL fair_data[%0d]: got %h expected %h", j, beat(j), exp);
            else pass_cnt++;
        end
        chk_cnt++;
        if (bcyc(15) - bcyc(0) != 22) $display("FAIL fair_span: got %0d expected 22", bcyc(15) - bcyc(0));
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int rdy_bad, grants;
        logic [NP-1:0] prev_sts, exp_rdy;
        logic [W-1:0] exp;
        bit pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        apply_reset();
        cfg_data    = 8'd4;
        src_base[1] = 32'h40;
        src_len[1]  = 6;
        src_en[1]   = 1'b1;
        rdy_bad  = 0;
        grants   = 0;
        prev_sts = '0;
        for (int c = 0; c < 100 && outq.size() < 6; c++) begin
            @(negedge aclk);
            exp_rdy = (sts_data == 4'b0010) ? {2'b00, (~m_tvalid | m_tready), 1'b0} : 4'b0000;
            if (s_tready !== exp_rdy) rdy_bad++;
            if (prev_sts == 4'b0000 && sts_data != 4'b0000) grants++;
            prev_sts = sts_data;
            m_tready = pat[c % 4];
        end
        chk_cnt++;
        if (outq.size() < 6) $display("FAIL bp_timeout: got %0d beats expected 6", outq.size());
        else pass_cnt++;
        m_tready = 1'b1;
        repeat (4) @(negedge aclk);
        for (int i = 0; i < 6; i++) begin
            exp = 32'h40 + W'(i);
            chk_cnt++;
            if (beat(i) !== exp) $display("FAIL bp_data[%0d]: got %h expected %h", i, beat(i), exp);
            else pass_cnt++;
        end
        chk_cnt++;
        if (outq.size() != 6) $display("FAIL bp_count: got %0d expected 6", outq.size());
        else pass_cnt++;
        chk_cnt++;
        if (rdy_bad != 0) $display("FAIL bp_s_tready: got %0d bad cycles expected 0", rdy_bad);
        else pass_cnt++;
        chk_cnt++;
        if (grants != 2) $display("FAIL bp_grants: got %0d expected 2", grants);
        else pass_cnt++;
    endtask

    task automatic test_early_release();
        bit refilled;
        logic [W-1:0] exp [8];
        exp[0] = 32'h50; exp[1] = 32'h51; exp[2] = 32'h52; exp[3] = 32'h80;
        exp[4] = 32'h81; exp[5] = 32'h53; exp[6] = 32'h54; exp[7] = 32'h55;
        apply_reset();
        cfg_data    = 8'd8;
        src_base[0] = 32'h50;
        src_len[0]  = 3;
        src_en[0]   = 1'b1;
        src_base[3] = 32'h80;
        src_len[3]  = 2;
        src_en[3]   = 1'b1;
        refilled = 1'b0;
        for (int c = 0; c < 100 && outq.size() < 8; c++) begin
            @(negedge aclk);
            // port0 requests again during the idle cycle; ptr must already point past it
            if (!refilled && src_cnt[0] == 3 && sts_data == 4'b0000) begin
                src_len[0] = 6;
                refilled   = 1'b1;
            end
        end
        chk_cnt++;
        if (outq.size() < 8) $display("FAIL early_timeout: got %0d beats expected 8", outq.size());
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            chk_cnt++;
            if (beat(i) !== exp[i]) $display("FAIL early_data[%0d]: got %h expected %h", i, beat(i), exp[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (bcyc(3) - bcyc(2) != 3) $display("FAIL early_gap: got %0d expected 3", bcyc(3) - bcyc(2));
        else pass_cnt++;
    endtask

    task automatic test_cfg_zero_and_reset();
        int grants;
        logic [NP-1:0] prev_sts, first_sts;
        logic [W-1:0] exp [4];
        exp[0] = 32'h60; exp[1] = 32'h70; exp[2] = 32'h61; exp[3] = 32'h71;
        apply_reset();
        cfg_data    = 8'd0;
        src_base[1] = 32'h60;
        src_len[1]  = 2;
        src_en[1]   = 1'b1;
        src_base[2] = 32'h70;
        src_len[2]  = 2;
        src_en[2]   = 1'b1;
        grants   = 0;
        prev_sts = '0;
        for (int c = 0; c < 60 && outq.size() < 4; c++) begin
            @(negedge aclk);
            if (prev_sts == 4'b0000 && sts_data != 4'b0000) grants++;
            prev_sts = sts_data;
        end
        chk_cnt++;
        if (outq.size() < 4) $display("FAIL zero_timeout: got %0d beats expected 4", outq.size());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (beat(i) !== exp[i]) $display("FAIL zero_data[%0d]: got %h expected %h", i, beat(i), exp[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (grants != 4) $display("FAIL zero_grants: got %0d expected 4", grants);
        else pass_cnt++;
        chk_cnt++;
        if (bcyc(3) - bcyc(0) != 6) $display("FAIL zero_span: got %0d expected 6", bcyc(3) - bcyc(0));
        else pass_cnt++;

        apply_reset();
        cfg_data    = 8'd3;
        src_base[0] = 32'h90;
        src_len[0]  = 100;
        src_en[0]   = 1'b1;
        src_base[2] = 32'hA0;
        src_len[2]  = 100;
        src_en[2]   = 1'b1;
        for (int c = 0; c < 50 && src_cnt[0] < 2; c++) @(negedge aclk);
        chk_cnt++;
        if (src_cnt[0] != 2) $display("FAIL midrst_timeout: got %0d beats expected 2", src_cnt[0]);
        else pass_cnt++;
        aresetn = 1'b0;
        #1;
        chk_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL midrst_m_tvalid: got %b expected 0", m_tvalid);
        else pass_cnt++;
        chk_cnt++;
        if (m_tdata !== 32'h0) $display("FAIL midrst_m_tdata: got %h expected 0", m_tdata);
        else pass_cnt++;
        chk_cnt++;
        if (sts_data !== 4'b0000) $display("FAIL midrst_sts: got %b expected 0000", sts_data);
        else pass_cnt++;
        chk_cnt++;
        if (s_tready !== 4'b0000) $display("FAIL midrst_s_tready: got %b expected 0000", s_tready);
        else pass_cnt++;
        repeat (2) @(negedge aclk);
        outq.delete();
        outcyc.delete();
        aresetn   = 1'b1;
        first_sts = '0;
        for (int c = 0; c < 50 && outq.size() < 1; c++) begin
            @(negedge aclk);
            if (first_sts == 4'b0000) first_sts = sts_data;
        end
        chk_cnt++;
        if (first_sts !== 4'b0001) $display("FAIL midrst_first_grant: got %b expected 0001", first_sts);
        else pass_cnt++;
        chk_cnt++;
        if (beat(0) !== 32'h92) $display("FAIL midrst_first_beat: got %h expected 00000092", beat(0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_fairness();
        test_backpressure();
        test_early_release();
        test_cfg_zero_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
